// File: rtl/pack_fifo.sv
// pack_fifo: parametrised packet buffer. Packets go into a power-of-two deep
// RAM and are presented through a stable valid/accept output register that
// counts toward the occupancy. It has a selectable overflow policy, occupancy
// and almost-full reporting, drop accounting, an activity stretch indicator
// and a synchronous flush.
module pack_fifo #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH_LOG2  = 9,
  parameter int DROP_OLDEST = 1,
  parameter int AFULL_LEVEL = 2**DEPTH_LOG2 - 4,
  parameter int IND_BITS    = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PkAvail,
  input  logic [DATA_WIDTH-1:0] Packet,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] Frame,
  output logic                  FrameValid,
  input  logic                  FrameNext,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  AlmostFull,
  output logic                  DataOverf,
  input  logic                  ClrOvf,
  output logic [15:0]           DropCount,
  output logic                  DataInd
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  // Dropping the oldest only makes sense when something sits behind the
  // output register; with a single entry the newcomer is discarded instead.
  localparam bit DROP_OK = (DROP_OLDEST != 0) && (DEPTH > 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_frame;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_fvalid;
  logic                  r_afull;
  logic                  r_ovf;
  logic [15:0]           r_dcnt;
  logic [IND_BITS-1:0]   r_ind;

  logic [DEPTH_LOG2:0]   w_ramcnt;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_drop_old;
  logic                  w_store;
  logic                  w_discard;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Entries still in RAM are the total level minus the presented one.
  assign w_ramcnt = r_level - {{DEPTH_LOG2{1'b0}}, r_fvalid};
  assign w_full   = (r_level == FULL_LVL);

  // Per-cycle transfer decisions; a flush suppresses every transfer.
  always_comb begin
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_drop_old  = 1'b0;
    w_store     = 1'b0;
    w_discard   = 1'b0;
    w_level_nxt = '0;
    if (!Flush) begin
      w_accept    = r_fvalid & FrameNext;
      w_load      = (w_ramcnt != '0) & (~r_fvalid | w_accept);
      w_drop_old  = DROP_OK & PkAvail & w_full & ~w_accept & r_fvalid;
      w_store     = PkAvail & (~w_full | w_accept | w_drop_old);
      w_discard   = (PkAvail & ~w_store) | w_drop_old;
      w_level_nxt = r_level + (DEPTH_LOG2+1)'(w_store)
                  - (DEPTH_LOG2+1)'(w_accept) - (DEPTH_LOG2+1)'(w_drop_old);
    end
  end

  // Packet storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst && w_store) r_mem[r_wptr] <= Packet;
  end

  // Registered RAM read straight into the output register, only when it is
  // empty or being accepted, so Frame holds steady otherwise.
  always_ff @(posedge clk) begin
    if (w_load) r_frame <= r_mem[r_rptr];
  end

  // Pointers, output-valid flag, occupancy and almost-full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fvalid <= 1'b0;
      r_level  <= '0;
      r_afull  <= (AFULL_LEVEL <= 0);
    end else begin
      r_level <= w_level_nxt;
      r_afull <= (32'(w_level_nxt) >= 32'(AFULL_LEVEL));
      if (Flush) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_fvalid <= 1'b0;
      end else begin
        if (w_store) r_wptr <= r_wptr + DEPTH_LOG2'(1);
        if (w_load || w_drop_old) r_rptr <= r_rptr + DEPTH_LOG2'(1);
        if (w_load) r_fvalid <= 1'b1;
        else if (w_accept) r_fvalid <= 1'b0;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a same-cycle discard
  // takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_dcnt <= '0;
    end else if (w_discard) begin
      r_ovf  <= 1'b1;
      r_dcnt <= ClrOvf ? 16'd1 : sat_inc(r_dcnt);
    end else if (ClrOvf) begin
      r_ovf  <= 1'b0;
      r_dcnt <= '0;
    end
  end

  // Activity stretch: reload on every stored packet, otherwise count down.
  always_ff @(posedge clk) begin
    if (!rst) r_ind <= '0;
    else if (w_store) r_ind <= '1;
    else if (r_ind != '0) r_ind <= r_ind - IND_BITS'(1);
  end

  assign Frame      = r_frame;
  assign FrameValid = r_fvalid;
  assign Level      = r_level;
  assign AlmostFull = r_afull;
  assign DataOverf  = r_ovf;
  assign DropCount  = r_dcnt;
  assign DataInd    = (r_ind != '0);

endmodule

// File: tb/tb_pack_fifo.sv
// Bench for pack_fifo: two instances (drop-oldest and drop-newest) share one
// stimulus stream; a queue-level model predicts every output each cycle, and
// directed sequences pin known values.
module tb_pack_fifo;

  logic clk;
  logic rst;
  logic PkAvail;
  logic [7:0] Packet;
  logic Flush;
  logic FrameNext;
  logic ClrOvf;

  logic [1:0][7:0]  o_frame;
  logic [1:0]       o_fv;
  logic [1:0][2:0]  o_lvl;
  logic [1:0]       o_af;
  logic [1:0]       o_ovf;
  logic [1:0][15:0] o_cnt;
  logic [1:0]       o_ind;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  // model state per instance: index 0 drops oldest, index 1 drops incoming
  int mq   [2][4];
  int mn   [2];
  bit mpres[2];
  bit movf [2];
  int mcnt [2];
  int mst  [2];

  int obs  [2][64];
  int obsn [2];

  pack_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .DROP_OLDEST(1), .AFULL_LEVEL(3), .IND_BITS(4)) u_old (
    .clk(clk), .rst(rst), .PkAvail(PkAvail), .Packet(Packet), .Flush(Flush),
    .Frame(o_frame[0]), .FrameValid(o_fv[0]), .FrameNext(FrameNext), .Level(o_lvl[0]),
    .AlmostFull(o_af[0]), .DataOverf(o_ovf[0]), .ClrOvf(ClrOvf), .DropCount(o_cnt[0]),
    .DataInd(o_ind[0]));

  pack_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .DROP_OLDEST(0), .AFULL_LEVEL(3), .IND_BITS(4)) u_new (
    .clk(clk), .rst(rst), .PkAvail(PkAvail), .Packet(Packet), .Flush(Flush),
    .Frame(o_frame[1]), .FrameValid(o_fv[1]), .FrameNext(FrameNext), .Level(o_lvl[1]),
    .AlmostFull(o_af[1]), .DataOverf(o_ovf[1]), .ClrOvf(ClrOvf), .DropCount(o_cnt[1]),
    .DataInd(o_ind[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic a, input logic [7:0] d, input logic fn, input logic fl, input logic cl);
    PkAvail = a; Packet = d; FrameNext = fn; Flush = fl; ClrOvf = cl;
    @(posedge clk); #1;
  endtask

  // Behavioural model: a queue whose head is presented one cycle after it is
  // in the buffer with nothing else presented.
  always @(posedge clk) begin
    bit acc, full, drop, stored;
    int left;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mn[k] = 0; mpres[k] = 0; movf[k] = 0; mcnt[k] = 0; mst[k] = 0;
      end else if (Flush) begin
        mn[k] = 0; mpres[k] = 0;
        if (mst[k] > 0) mst[k]--;
        if (ClrOvf) begin movf[k] = 0; mcnt[k] = 0; end
      end else begin
        acc = mpres[k] && FrameNext;
        full = (mn[k] == 4);
        drop = 0; stored = 0;
        if (acc) begin
          for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        left = mn[k];
        if (PkAvail) begin
          if (!full || acc) begin
            mq[k][mn[k]] = int'(Packet); mn[k]++; stored = 1;
          end else if (k == 0) begin
            // remove the oldest entry not yet presented
            for (int i = (mpres[k] ? 1 : 0); i < 3; i++) mq[k][i] = mq[k][i+1];
            mq[k][3] = int'(Packet); stored = 1; drop = 1;
          end else begin
            drop = 1;
          end
        end
        mpres[k] = (left > 0);
        if (drop) begin
          movf[k] = 1;
          mcnt[k] = ClrOvf ? 1 : ((mcnt[k] == 65535) ? 65535 : mcnt[k] + 1);
        end else if (ClrOvf) begin
          movf[k] = 0; mcnt[k] = 0;
        end
        if (stored) mst[k] = 15;
        else if (mst[k] > 0) mst[k]--;
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid[%0d]", k), 32'(o_fv[k]), 32'(mpres[k]));
        if (mpres[k]) chk($sformatf("frame[%0d]", k), 32'(o_frame[k]), 32'(mq[k][0]));
        chk($sformatf("level[%0d]", k), 32'(o_lvl[k]), 32'(mn[k]));
        chk($sformatf("afull[%0d]", k), 32'(o_af[k]), 32'(mn[k] >= 3));
        chk($sformatf("ovf[%0d]", k), 32'(o_ovf[k]), 32'(movf[k]));
        chk($sformatf("dropcnt[%0d]", k), 32'(o_cnt[k]), 32'(mcnt[k]));
        chk($sformatf("ind[%0d]", k), 32'(o_ind[k]), 32'(mst[k] != 0));
        if (o_fv[k] && FrameNext && rst && !Flush && obsn[k] < 64) begin
          obs[k][obsn[k]] = int'(o_frame[k]);
          obsn[k]++;
        end
      end
    end
  end

  initial begin
    int exp0 [4];
    int exp1 [4];
    int afill;
    rst = 1'b0;
    PkAvail = 0; Packet = 0; Flush = 0; FrameNext = 0; ClrOvf = 0;
    obsn[0] = 0; obsn[1] = 0;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    rst = 1'b1;
    cmp_en = 1;

    // reset state
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 32'(o_fv[k]), 0);
      chk("rst_level", 32'(o_lvl[k]), 0);
      chk("rst_afull", 32'(o_af[k]), 0);
      chk("rst_ovf", 32'(o_ovf[k]), 0);
      chk("rst_cnt", 32'(o_cnt[k]), 0);
      chk("rst_ind", 32'(o_ind[k]), 0);
    end

    // single packet, consumer always ready: two-cycle latency, Level 0,1,0
    cyc(1, 8'h11, 1, 0, 0);
    chk("t1_lvl1", 32'(o_lvl[0]), 1);
    chk("t1_v0", 32'(o_fv[0]), 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t1_v1", 32'(o_fv[0]), 1);
    chk("t1_frame", 32'(o_frame[0]), 32'h11);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t1_v_end", 32'(o_fv[0]), 0);
    chk("t1_lvl_end", 32'(o_lvl[0]), 0);

    // fill to capacity, then overflow with 0x05
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t2_lvl", 32'(o_lvl[0]), 4);
    chk("t2_head", 32'(o_frame[0]), 32'h01);
    chk("t2_afull", 32'(o_af[1]), 1);
    cyc(1, 8'h05, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("t3_ovf", 32'(o_ovf[k]), 1);
      chk("t3_cnt", 32'(o_cnt[k]), 1);
      chk("t3_lvl", 32'(o_lvl[k]), 4);
    end
    obsn[0] = 0; obsn[1] = 0;
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0);
    exp0 = '{1, 3, 4, 5};
    exp1 = '{1, 2, 3, 4};
    chk("t3_n_old", 32'(obsn[0]), 4);
    chk("t3_n_new", 32'(obsn[1]), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain_old[%0d]", i), 32'(obs[0][i]), 32'(exp0[i]));
      chk($sformatf("t3_drain_new[%0d]", i), 32'(obs[1][i]), 32'(exp1[i]));
    end
    chk("t3_lvl_end", 32'(o_lvl[0]), 0);

    // clear overflow status
    cyc(0, 8'h00, 0, 0, 1);
    chk("t4_ovf", 32'(o_ovf[1]), 0);
    chk("t4_cnt", 32'(o_cnt[1]), 0);

    // full with simultaneous write and accept, then flush with a write
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    cyc(1, 8'h66, 1, 0, 0);
    chk("t5_lvl", 32'(o_lvl[0]), 4);
    chk("t5_cnt", 32'(o_cnt[0]), 0);
    cyc(1, 8'h77, 0, 1, 0);
    chk("t5_fl_lvl", 32'(o_lvl[0]), 0);
    chk("t5_fl_v", 32'(o_fv[0]), 0);
    chk("t5_fl_cnt", 32'(o_cnt[1]), 0);

    // reset in mid-operation with Level=3 and overflow set
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hA1 + i), 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t6_pre_lvl", 32'(o_lvl[0]), 3);
    chk("t6_pre_ovf", 32'(o_ovf[0]), 1);
    rst = 1'b0;
    cyc(1, 8'hEE, 1, 0, 0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_lvl", 32'(o_lvl[k]), 0);
      chk("t6_v", 32'(o_fv[k]), 0);
      chk("t6_ovf", 32'(o_ovf[k]), 0);
      chk("t6_cnt", 32'(o_cnt[k]), 0);
      chk("t6_ind", 32'(o_ind[k]), 0);
      chk("t6_af", 32'(o_af[k]), 0);
    end

    // activity stretch: high for 15 cycles after the last stored write
    cyc(1, 8'h42, 1, 0, 0);
    chk("t7_ind_on", 32'(o_ind[0]), 1);
    for (int i = 0; i < 14; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("t7_ind_hold", 32'(o_ind[0]), 1);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t7_ind_off", 32'(o_ind[1]), 0);

    // randomized traffic with varying consumer readiness
    afill = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) afill = int'($urandom_range(10, 90));
      rst = ($urandom_range(0, 199) != 0);
      cyc(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < afill),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3));
    end
    rst = 1'b1;
    cyc(0, 8'h00, 0, 0, 0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
Name: pack_fifo

Overview:
- Parametrised successor to the single-width packet buffer.
- Sits between the packet processor and the output frame handler, in one clock domain.
- Stores packets of configurable width in a power-of-two deep RAM and presents them through a stable valid/accept output stage.
- Adds selectable overflow policy, occupancy and almost-full reporting, a saturating drop counter, a sticky overflow flag and a synchronous flush.

Parameters:
- DATA_WIDTH, 128, packet/frame width in bits.
- DEPTH_LOG2, 9, log2 of total capacity; DEPTH = 2^DEPTH_LOG2 entries, all usable.
- DROP_OLDEST, 1, overflow policy: 1 = discard oldest un-presented entry and store the new one; 0 = discard the incoming packet.
- AFULL_LEVEL, 2^DEPTH_LOG2-4, Level at or above which AlmostFull asserts.
- IND_BITS, 26, width of the data-activity stretch counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- PkAvail  in  1  one-cycle write strobe; Packet is valid when high.
- Packet  in  DATA_WIDTH  incoming packet word.
- Flush  in  1  one-cycle request to empty the buffer.
- Frame  out  DATA_WIDTH  head packet; stable while FrameValid=1 and FrameNext=0.
- FrameValid  out  1  Frame holds a valid packet.
- FrameNext  in  1  consumer accepts Frame; transfer occurs when FrameValid & FrameNext.
- Level  out  DEPTH_LOG2+1  stored entries including the output stage, range 0..DEPTH.
- AlmostFull  out  1  Level >= AFULL_LEVEL.
- DataOverf  out  1  sticky: at least one packet discarded since reset/ClrOvf.
- ClrOvf  in  1  clears DataOverf and DropCount.
- DropCount  out  16  saturating count of discarded packets.
- DataInd  out  1  high while the stretch counter is non-zero.

Behaviour:
- Reset (rst=0 at a clk edge) clears all state:
  - FrameValid=0, Level=0, AlmostFull=0 (when AFULL_LEVEL>0), DataOverf=0, DropCount=0, DataInd=0.
  - Frame is don't-care.
  - Read and write pointers = 0, stretch counter = 0.
  - Reset mid-operation discards all contents; the same cycle's PkAvail and FrameNext are ignored.
- Storage:
  - Dual-port RAM, one-cycle registered read, plus one output register.
  - The output register counts toward Level; capacity stays exactly DEPTH.
- Write path:
  - PkAvail is a level-sampled strobe with no edge detection; each high cycle is one packet.
  - Not full, or full with a same-cycle accept: the packet is stored and Level increments, or stays unchanged on a simultaneous accept.
  - Full with no accept and DROP_OLDEST=1:
    - The oldest entry still in RAM is discarded (read pointer advances) and the new packet is stored. Level stays DEPTH.
    - The packet in the output register is never altered.
    - With DEPTH=1 (the only entry is in the output register), the incoming packet is discarded instead.
  - Full with no accept and DROP_OLDEST=0: the incoming packet is discarded.
  - Any discard sets DataOverf and increments DropCount, saturating at 16'hFFFF.
- Output path:
  - Latency from PkAvail into an empty buffer to FrameValid=1 is 2 cycles.
  - An accept with more data behind it presents the next entry the following cycle with FrameValid held high, giving full throughput of 1 frame/cycle.
  - An accept of the last entry drops FrameValid the next cycle.
  - FrameNext while FrameValid=0 is ignored.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Flush:
  - Next cycle: Level=0, FrameValid=0, pointers equal.
  - A PkAvail in the flush cycle is discarded without counting as a drop.
  - A FrameNext in the flush cycle is ignored.
  - DataOverf and DropCount are unaffected.
- ClrOvf:
  - Clears DataOverf and DropCount.
  - If a discard occurs in the same cycle, the discard wins: DataOverf=1, DropCount=1.
- Stretch counter:
  - Loaded with all-ones on every stored packet, otherwise decremented toward 0.
  - Dropped packets under DROP_OLDEST=0 do not load it.
- Level and AlmostFull are registered and update the cycle after the event.

Test Plan:
- DATA_WIDTH=8, DEPTH_LOG2=2: write 0x11, FrameNext=1 held -> FrameValid=1 with Frame=0x11 two cycles later, then FrameValid=0; Level sequence 0,1,0.
- Write 0x01..0x04 with FrameNext=0 -> Level=4, Frame=0x01 stable. Accept four consecutive cycles -> Frame 0x01,0x02,0x03,0x04 back-to-back, then Level=0.
- DROP_OLDEST=1, full with 0x01..0x04, write 0x05 -> DataOverf=1, DropCount=1. Drain yields 0x01,0x03,0x04,0x05 (0x02 dropped; head 0x01 untouched).
- DROP_OLDEST=0, same stimulus -> drain yields 0x01..0x04, DropCount=1. Then pulse ClrOvf -> DataOverf=0, DropCount=0.
- Full buffer with PkAvail and FrameNext in the same cycle -> no drop, Level stays 4. Then Flush together with PkAvail -> Level=0, FrameValid=0 next cycle, DropCount unchanged.
- Mid-stream rst=0 for one cycle with Level=3 -> all outputs at reset values on the next edge. IND_BITS=4: DataInd falls 15 cycles after the last stored write.
